// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Purpose  : Synchronises WIDTH raw board switches into the clk domain and
//            debounces each bit with its own stability counter. Produces a
//            clean level bus for the CPU plus registered one-cycle
//            rise/fall/change strobes.
// Options  : SWITCH_DEBOUNCER_CHANGE_LATCH_EN - enables the sticky
//            change_pending flag (cleared by change_ack). Without it,
//            change_pending is tied to 0 and change_ack is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    input  logic             change_ack,
    output logic             change_pending
);

    // Terminal count: the mismatch run that reaches this value commits the
    // new level. STABLE_CYCLES may equal 2^CNT_W, so STABLE_CYCLES-1 fits.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time configuration checks
    // ------------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("switch_debouncer: SYNC_STAGES must be 2 or more");
    end

    if ((STABLE_CYCLES < 1) ||
        (longint'(STABLE_CYCLES) > (longint'(1) << CNT_W))) begin : g_bad_stable_cycles
        $error("switch_debouncer: STABLE_CYCLES must be in 1 .. 2**CNT_W");
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("switch_debouncer: WIDTH must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    // r_sync[0] samples the raw pins; r_sync[SYNC_STAGES-1] is the
    // synchronised value the debouncers look at.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync;
    logic [WIDTH-1:0]                  w_accept;

    logic [WIDTH-1:0]                  r_stable;
    logic [WIDTH-1:0]                  r_rise;
    logic [WIDTH-1:0]                  r_fall;
    logic                              r_changed;

    // ------------------------------------------------------------------------
    // Synchroniser: plain shift chain, no logic between stages
    // ------------------------------------------------------------------------
    // Shift the raw switch levels through SYNC_STAGES flops
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Per-bit stability counters
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;
        logic             w_mismatch;
        logic             w_done;

        assign w_mismatch  = w_sync[i] ^ r_stable[i];
        assign w_done      = w_mismatch && (r_cnt == c_LAST);
        assign w_accept[i] = w_done;

        // Count consecutive mismatching edges; any match or a commit restarts
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                r_cnt <= '0;
            end else if (!w_mismatch || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Debounced level and event strobes
    // ------------------------------------------------------------------------
    // Flip accepted bits and register the matching edge strobes
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_stable  <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_stable  <= r_stable ^ w_accept;
            r_rise    <= w_accept & ~r_stable;
            r_fall    <= w_accept &  r_stable;
            r_changed <= |w_accept;
        end
    end

    assign sw_stable  = r_stable;
    assign sw_rise    = r_rise;
    assign sw_fall    = r_fall;
    assign sw_changed = r_changed;

    // ------------------------------------------------------------------------
    // Optional sticky change flag
    // ------------------------------------------------------------------------
`ifdef SWITCH_DEBOUNCER_CHANGE_LATCH_EN
    logic r_pending;

    // A new change wins over an acknowledge on the same edge
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pending <= 1'b0;
        end else if (|w_accept) begin
            r_pending <= 1'b1;
        end else if (change_ack) begin
            r_pending <= 1'b0;
        end
    end

    assign change_pending = r_pending;
`else
    // Port kept so both builds share one top-level footprint
    logic w_unused_change_ack;
    assign w_unused_change_ack = change_ack;
    assign change_pending      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debouncer
// Purpose  : Self-checking bench for switch_debouncer (SYNC_STAGES=2,
//            STABLE_CYCLES=4) with directed scenarios, randomized stimulus
//            and a window-based behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int c_W  = 8;
    localparam int c_SS = 2;
    localparam int c_SC = 4;

    logic           clk = 1'b0;
    logic           clr = 1'b0;
    logic [c_W-1:0] sw_raw = '0;
    logic           change_ack = 1'b0;
    logic [c_W-1:0] sw_stable, sw_rise, sw_fall;
    logic           sw_changed, change_pending;

    int checks   = 0;
    int failures = 0;

    switch_debouncer #(
        .WIDTH        (c_W),
        .SYNC_STAGES  (c_SS),
        .STABLE_CYCLES(c_SC),
        .CNT_W        (16)
    ) u_dut (
        .clk           (clk),
        .clr           (clr),
        .sw_raw        (sw_raw),
        .sw_stable     (sw_stable),
        .sw_rise       (sw_rise),
        .sw_fall       (sw_fall),
        .sw_changed    (sw_changed),
        .change_ack    (change_ack),
        .change_pending(change_pending)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: a bit takes a new level when the last c_SC
    // synchronised samples all differ from its current level. Samples reach
    // the comparison c_SS edges after the raw pins are sampled.
    // ------------------------------------------------------------------------
    logic [c_W-1:0] m_pipe [c_SS];
    logic [c_W-1:0] m_hist [c_SC-1];
    logic [c_W-1:0] m_stable, m_rise, m_fall, m_accept;
    logic           m_changed, m_pending;
    logic [3*c_W+1:0] m_vec, d_vec;

    always_comb begin
        m_accept = m_pipe[c_SS-1] ^ m_stable;
        for (int k = 0; k < c_SC-1; k++) m_accept = m_accept & (m_hist[k] ^ m_stable);
    end

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int k = 0; k < c_SS; k++) m_pipe[k] <= '0;
            for (int k = 0; k < c_SC-1; k++) m_hist[k] <= '0;
            m_stable  <= '0;
            m_rise    <= '0;
            m_fall    <= '0;
            m_changed <= 1'b0;
            m_pending <= 1'b0;
        end else begin
            m_pipe[0] <= sw_raw;
            for (int k = 1; k < c_SS; k++) m_pipe[k] <= m_pipe[k-1];
            m_hist[0] <= m_pipe[c_SS-1];
            for (int k = 1; k < c_SC-1; k++) m_hist[k] <= m_hist[k-1];
            m_stable  <= m_stable ^ m_accept;
            m_rise    <= m_accept & ~m_stable;
            m_fall    <= m_accept & m_stable;
            m_changed <= (m_accept != '0);
`ifdef SWITCH_DEBOUNCER_CHANGE_LATCH_EN
            if (m_accept != '0)  m_pending <= 1'b1;
            else if (change_ack) m_pending <= 1'b0;
`endif
        end
    end

    assign m_vec = {m_stable, m_rise, m_fall, m_changed, m_pending};
    assign d_vec = {sw_stable, sw_rise, sw_fall, sw_changed, change_pending};

    // Drive a level and let it settle fully (no checking here)
    task automatic settle(input logic [c_W-1:0] v);
        sw_raw = v;
        repeat (10) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        clr = 1'b0;
        sw_raw = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (d_vec !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", c, d_vec);
            end
        end
        clr = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (e < 6 && d_vec !== '0) begin
                failures++;
                $display("FAIL reset_release edge=%0d got=%h exp=0", e, d_vec);
            end
            if (e == 6 && (sw_stable !== 8'hFF || sw_rise !== 8'hFF ||
                           sw_fall !== 8'h00 || sw_changed !== 1'b1)) begin
                failures++;
                $display("FAIL reset_rise edge=6 stable=%h rise=%h fall=%h chg=%b exp=ff/ff/00/1",
                         sw_stable, sw_rise, sw_fall, sw_changed);
            end
            if (e == 7 && (sw_stable !== 8'hFF || sw_rise !== 8'h00 || sw_changed !== 1'b0)) begin
                failures++;
                $display("FAIL reset_pulse_end edge=7 stable=%h rise=%h chg=%b exp=ff/00/0",
                         sw_stable, sw_rise, sw_changed);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_latency();
        settle(8'h00);
        sw_raw = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (sw_stable !== ((e >= 6) ? 8'h01 : 8'h00) ||
                sw_rise   !== ((e == 6) ? 8'h01 : 8'h00) || sw_fall !== 8'h00) begin
                failures++;
                $display("FAIL latency edge=%0d stable=%h rise=%h fall=%h", e, sw_stable, sw_rise, sw_fall);
            end
            checks++;
            if (d_vec !== m_vec) begin
                failures++;
                $display("FAIL latency_model edge=%0d got=%h exp=%h", e, d_vec, m_vec);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bounce();
        int rises;
        logic [0:6] pat;
        pat = 7'b1110111;
        settle(8'h00);
        rises = 0;
        for (int e = 1; e <= 20; e++) begin
            sw_raw = (e <= 7) ? {4'b0, pat[e-1], 3'b0} : 8'h08;
            @(negedge clk);
            if (sw_rise[3] === 1'b1) rises++;
            checks++;
            if (sw_stable[3] !== (e >= 10)) begin
                failures++;
                $display("FAIL bounce_level edge=%0d got=%b exp=%b", e, sw_stable[3], (e >= 10));
            end
            checks++;
            if (d_vec !== m_vec) begin
                failures++;
                $display("FAIL bounce_model edge=%0d got=%h exp=%h", e, d_vec, m_vec);
            end
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL bounce_rise_count got=%0d exp=1", rises);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_simultaneous();
        int chg;
        settle(8'h0F);
        sw_raw = 8'hF0;
        chg = 0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (sw_changed === 1'b1) chg++;
            if (e == 6) begin
                checks++;
                if (sw_stable !== 8'hF0 || sw_rise !== 8'hF0 || sw_fall !== 8'h0F || sw_changed !== 1'b1) begin
                    failures++;
                    $display("FAIL simul_edge6 stable=%h rise=%h fall=%h chg=%b exp=f0/f0/0f/1",
                             sw_stable, sw_rise, sw_fall, sw_changed);
                end
            end
            checks++;
            if (d_vec !== m_vec) begin
                failures++;
                $display("FAIL simul_model edge=%0d got=%h exp=%h", e, d_vec, m_vec);
            end
        end
        checks++;
        if (chg != 1) begin
            failures++;
            $display("FAIL simul_changed_count got=%0d exp=1", chg);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        settle(8'h00);
        sw_raw = 8'h80;
        repeat (4) @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (d_vec !== '0) begin
            failures++;
            $display("FAIL midreset_hold got=%h exp=0", d_vec);
        end
        clr = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (sw_stable !== ((e >= 6) ? 8'h80 : 8'h00) || sw_rise !== ((e == 6) ? 8'h80 : 8'h00)) begin
                failures++;
                $display("FAIL midreset edge=%0d stable=%h rise=%h", e, sw_stable, sw_rise);
            end
            checks++;
            if (d_vec !== m_vec) begin
                failures++;
                $display("FAIL midreset_model edge=%0d got=%h exp=%h", e, d_vec, m_vec);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_change_latch();
        logic exp_p;
        settle(8'h00);
        // Ack with nothing pending: no change to the flag
        change_ack = 1'b1;
        @(negedge clk);
        change_ack = 1'b0;
        sw_raw = 8'h42;
        for (int e = 1; e <= 12; e++) begin
            change_ack = (e == 6 || e == 10);   // e==6: ack lands on the commit edge
            @(negedge clk);
`ifdef SWITCH_DEBOUNCER_CHANGE_LATCH_EN
            exp_p = (e >= 6 && e < 10);
`else
            exp_p = 1'b0;
`endif
            checks++;
            if (change_pending !== exp_p) begin
                failures++;
                $display("FAIL change_pending edge=%0d got=%b exp=%b", e, change_pending, exp_p);
            end
        end
        change_ack = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        int hold;
        for (int n = 0; n < 300; n++) begin
            sw_raw = c_W'($urandom);
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                change_ack = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                checks++;
                if (d_vec !== m_vec) begin
                    failures++;
                    $display("FAIL random_model n=%0d c=%0d got=%h exp=%h", n, c, d_vec, m_vec);
                end
                checks++;
                if ((sw_rise & sw_fall) !== '0) begin
                    failures++;
                    $display("FAIL random_rise_fall_overlap got=%h exp=0", sw_rise & sw_fall);
                end
            end
        end
        change_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_change_latch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input conditioning stage that sits directly upstream of the CPU's `swiches` input.
- Synchronises the 8 raw board switches into the `clk` domain and debounces each bit independently with a per-bit stability counter.
- Drives a clean, glitch-free `sw_stable` bus to the CPU, plus one-cycle rise/fall/change strobes for later event-driven logic.

Parameters:
- WIDTH, 8: number of switch bits.
- SYNC_STAGES, 2: flip-flop stages in the synchroniser; legal range is 2 or more.
- STABLE_CYCLES, 50000: consecutive mismatching clock edges required to accept a new level; legal range is 1 to 2^CNT_W.
- CNT_W, 16: width of each per-bit debounce counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-low reset; clr=0 immediately forces all state to its reset value.
- sw_raw  in  WIDTH  raw, asynchronous switch levels from the board.
- sw_stable  out  WIDTH  debounced switch levels; connects to the CPU `swiches` input.
- sw_rise  out  WIDTH  one-cycle pulse per bit when `sw_stable` goes 0->1.
- sw_fall  out  WIDTH  one-cycle pulse per bit when `sw_stable` goes 1->0.
- sw_changed  out  1  one-cycle pulse; equals OR of (sw_rise | sw_fall).
- change_ack  in  1  clears change_pending; used only with the optional feature.
- change_pending  out  1  sticky change flag; used only with the optional feature.

Behaviour:
- Reset (clr=0, asynchronous): all synchroniser stages, counters, sw_stable, sw_rise, sw_fall, sw_changed and change_pending go to 0. This holds regardless of clock and of any in-progress count.
- Synchroniser:
  - sw_raw passes through SYNC_STAGES registered stages; the last stage is `sync[i]`.
  - No combinational path exists from sw_raw to any output.
- Per-bit debounce, bit i, at each rising clk edge:
  - If sync[i] == sw_stable[i]: cnt[i] <= 0; no pulse.
  - If sync[i] != sw_stable[i] and cnt[i] != STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If sync[i] != sw_stable[i] and cnt[i] == STABLE_CYCLES-1: sw_stable[i] <= sync[i], cnt[i] <= 0, and sw_rise[i] or sw_fall[i] is asserted for exactly this one cycle.
- Bounce: any single edge with sync[i] == sw_stable[i] restarts the count from 0. A glitch shorter than STABLE_CYCLES synchronised cycles never reaches sw_stable.
- Latency: sw_raw changes and then holds. sw_stable updates on rising edge number SYNC_STAGES+STABLE_CYCLES after the change, counting the first edge that samples the new value as edge 1.
- STABLE_CYCLES=1: the new level is accepted on the first mismatching edge and the counter stays 0.
- Counter arithmetic:
  - Unsigned, width CNT_W.
  - It never exceeds STABLE_CYCLES-1, so it cannot wrap.
  - Configurations with STABLE_CYCLES > 2^CNT_W are illegal and must be rejected by an elaboration-time check.
- Bit independence: bits count independently. Several bits may update on the same edge; sw_rise and sw_fall may both be nonzero in that cycle on different bits.
- Pulse outputs:
  - Registered, one cycle wide, 0 in every cycle with no update.
  - sw_rise[i] and sw_fall[i] are never both 1.
- Reset mid-count: reset discards partial counts. After clr returns high, a switch held at 1 needs the full SYNC_STAGES+STABLE_CYCLES edges to appear, and then produces an sw_rise pulse.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_CHANGE_LATCH_EN.
- Defined:
  - change_pending <= 1 on any edge where sw_changed would be 1.
  - Otherwise, change_pending <= 0 when change_ack=1.
  - Simultaneous new change and change_ack leaves change_pending=1, so no event is lost.
  - change_ack with no pending change has no effect.
- Not defined:
  - change_pending is constant 0 and change_ack is ignored.
  - The ports remain present so the top level is identical in both builds.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2 unless noted):
- Reset: hold clr=0 with sw_raw=8'hFF for 10 cycles, then release -> all outputs 0 during reset; sw_stable=8'hFF on the 6th edge after release; sw_rise=8'hFF for that single cycle; sw_changed=1 for that single cycle.
- Latency: from sw_stable=8'h00, set sw_raw=8'h01 and hold -> sw_stable=8'h01 exactly at edge 6; sw_rise=8'h01 for one cycle; sw_fall=0.
- Bounce: on bit 3, apply 1 for 3 cycles, 0 for 1 cycle, 1 for 3 cycles, then 1 steady -> no change during the bursts; sw_stable[3] rises only after 4 consecutive synchronised 1s; exactly one sw_rise pulse.
- Simultaneous: from 8'h0F, switch sw_raw to 8'hF0 in one cycle -> after 6 edges, sw_stable=8'hF0, sw_rise=8'hF0 and sw_fall=8'h0F, all in the same single cycle; sw_changed=1 once.
- Reset mid-count: drive sw_raw=8'h80, pull clr low after 4 edges, release, keep sw_raw=8'h80 -> sw_stable stays 0 until 6 edges after release, then 8'h80.
- Optional feature (macro defined): trigger a change while change_ack=1 on the same edge -> change_pending=1. A later ack alone -> change_pending=0. Macro undefined -> change_pending=0 throughout.
